cpu_phase_controller: RTL and testbench
=======================================

// Module: cpu_phase_controller
// PURPOSE
//  Control sequencer for the 8-bit accumulator CPU: 5-bit PC, 32x8 memory, 3-bit opcode.
//  Steps an 8-phase instruction cycle and decodes phase + opcode into datapath strobes.
//  Stalls on slow memory reads, latches HALT, and flags memory timeouts.
//  Sits inside cpu between instruction register/ALU zero flag and the PC/AC/IR/memory.
// PARAMETERS
//  WAIT_LIMIT  15  max consecutive stall cycles in one read phase before timeout (1..255)
// PORTS
//  CLK      in   1  single clock; all state changes on posedge
//  RST      in   1  synchronous, active-high reset
//  opcode   in   3  IR[7:5]: HLT=0 SKZ=1 ADD=2 AND=3 XOR=4 LDA=5 STO=6 JMP=7
//  zero     in   1  accumulator==0, sampled in phase 6
//  mem_rdy  in   1  memory read data valid this cycle
//  sel      out  1  address mux: 1=PC, 0=IR operand
//  rd       out  1  memory read enable
//  ld_ir    out  1  load instruction register
//  inc_pc   out  1  increment PC
//  ld_pc    out  1  load PC from IR operand
//  ld_ac    out  1  load accumulator from ALU
//  wr       out  1  memory write strobe
//  data_e   out  1  drive AC onto data bus
//  halt     out  1  sticky halt
//  err      out  1  sticky memory timeout
//  phase    out  3  current phase, for debug
// BEHAVIOUR
//  Reset: phase=0, halt=0, err=0, wait_cnt=0. Every strobe output is forced to 0 while RST=1.
//  phase is a 3-bit counter. It advances by 1 per cycle, and 7 wraps to 0.
//  Hold conditions, in priority order:
//   halt or err asserted -> frozen.
//   phase 1, mem_rdy=0 -> stall.
//   phase 5, opcode in {ADD,AND,XOR,LDA}, mem_rdy=0 -> stall.
//  Stall counter wait_cnt:
//   increments on each stall cycle; clears on advance.
//   if a stall cycle is taken with wait_cnt==WAIT_LIMIT-1: err<=1 and halt<=1 (timeout).
//  Strobes are a combinational decode of phase/opcode. ALUOP = ADD|AND|XOR|LDA.
//   ph0 INST_ADDR  : sel
//   ph1 INST_FETCH : sel rd
//   ph2 INST_LOAD  : sel rd ld_ir
//   ph3 IDLE       : sel rd ld_ir
//   ph4 OP_ADDR    : inc_pc, unless opcode==HLT; HLT sets halt<=1 instead
//   ph5 OP_FETCH   : rd if ALUOP
//   ph6 ALU_OP     : rd if ALUOP; inc_pc if SKZ&zero; ld_pc if JMP; data_e if STO
//   ph7 STORE      : rd,ld_ac if ALUOP; ld_pc if JMP; wr,data_e if STO
//  While stalled, the phase's strobes stay asserted, except ld_ir/ld_ac. Each of those
//  pulses exactly once per instruction.
//  halt rises the cycle after ph4 with HLT. From then on phase holds at 4, every strobe is 0
//  and halt/err hold until RST. No instruction can clear them.
//  RST mid-instruction has priority over stall, halt and timeout. Next cycle is phase 0.
//  inc_pc and ld_pc are never both 1. wr is asserted only in ph7.
// STRUCTURE
//  cpu_pkg:
//   opcode localparams (HLT..JMP)
//   phase localparams (INST_ADDR..STORE)
//   function is_aluop(opcode)
//  Sub-module cpu_phase_decode: purely combinational phase/opcode -> strobe table.
//  Top level holds phase counter, stall/wait counter, halt/err flags and the RST/halt gating.
// TESTING
//  1 RST 2 clks, mem_rdy=1, opcode=LDA -> phases 0..7 repeat; ld_ir@ph2, inc_pc@ph4,
//    ld_ac@ph7; 8 cycles/instr.
//  2 opcode=HLT, mem_rdy=1 -> halt=1 one cycle after ph4; phase stays 4; strobes 0 for
//    20 cycles.
//  3 SKZ: zero=1 -> inc_pc in ph4 and ph6 (2 incs); zero=0 -> inc_pc only in ph4.
//  4 JMP -> ld_pc=1 in ph6,7; STO -> data_e ph6,7 and wr only ph7; inc_pc=0 in ph6
//    for both.
//  5 mem_rdy=0 for 3 cycles at ph1 -> phase held at 1 for 4 cycles, rd=1 throughout,
//    err=0, then ph2.
//  6 mem_rdy=0 held at ph5 with ADD, WAIT_LIMIT=15 -> err=1,halt=1 after 15 stall
//    cycles; RST -> phase 0, flags 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode and phase encodings, the datapath strobe bundle and the
// ALU-opcode predicate used by the accumulator CPU control path.
package cpu_pkg;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  localparam logic [2:0] PH_INST_ADDR  = 3'd0;
  localparam logic [2:0] PH_INST_FETCH = 3'd1;
  localparam logic [2:0] PH_INST_LOAD  = 3'd2;
  localparam logic [2:0] PH_IDLE       = 3'd3;
  localparam logic [2:0] PH_OP_ADDR    = 3'd4;
  localparam logic [2:0] PH_OP_FETCH   = 3'd5;
  localparam logic [2:0] PH_ALU_OP     = 3'd6;
  localparam logic [2:0] PH_STORE      = 3'd7;

  typedef struct packed {
    logic sel;
    logic rd;
    logic ld_ir;
    logic inc_pc;
    logic ld_pc;
    logic ld_ac;
    logic wr;
    logic data_e;
  } strobes_t;

  // Opcodes that read an operand from memory and load the accumulator.
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_phase_decode.sv
// Purely combinational phase/opcode -> datapath strobe table; the top level
// applies reset, halt and stall gating on top of this.
module cpu_phase_decode
  import cpu_pkg::*;
(
  input  logic [2:0] phase_i,
  input  logic [2:0] opcode_i,
  input  logic       zero_i,
  output strobes_t   strobes_o
);

  logic aluop;

  assign aluop = is_aluop(opcode_i);

  always_comb begin
    strobes_o = '0;
    case (phase_i)
      PH_INST_ADDR: begin
        strobes_o.sel = 1'b1;
      end
      PH_INST_FETCH: begin
        strobes_o.sel = 1'b1;
        strobes_o.rd  = 1'b1;
      end
      PH_INST_LOAD, PH_IDLE: begin
        strobes_o.sel   = 1'b1;
        strobes_o.rd    = 1'b1;
        strobes_o.ld_ir = 1'b1;
      end
      PH_OP_ADDR: begin
        // HLT suppresses the PC increment; the top level latches halt instead.
        strobes_o.inc_pc = (opcode_i != OP_HLT);
      end
      PH_OP_FETCH: begin
        strobes_o.rd = aluop;
      end
      PH_ALU_OP: begin
        strobes_o.rd     = aluop;
        strobes_o.inc_pc = (opcode_i == OP_SKZ) && zero_i;
        strobes_o.ld_pc  = (opcode_i == OP_JMP);
        strobes_o.data_e = (opcode_i == OP_STO);
      end
      PH_STORE: begin
        strobes_o.rd     = aluop;
        strobes_o.ld_ac  = aluop;
        strobes_o.ld_pc  = (opcode_i == OP_JMP);
        strobes_o.wr     = (opcode_i == OP_STO);
        strobes_o.data_e = (opcode_i == OP_STO);
      end
    endcase
  end

endmodule

// File: rtl/cpu_phase_controller.sv
// Control sequencer for the 8-bit accumulator CPU: steps the 8-phase instruction
// cycle, stalls on slow memory reads, and latches HALT and memory timeouts.
module cpu_phase_controller
  import cpu_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       mem_rdy,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       wr,
  output logic       data_e,
  output logic       halt,
  output logic       err,
  output logic [2:0] phase
);

  localparam logic [7:0] LAST_WAIT = 8'(WAIT_LIMIT - 1);

  logic [2:0] phase_q, phase_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       halt_q, halt_d;
  logic       err_q, err_d;
  logic       frozen, read_phase, stall, hlt_now, live;
  strobes_t   dec_strobes;

  // mem_rdy handshake: a read phase (1, or 5 for ALU ops) completes only in a cycle
  // with mem_rdy=1; otherwise it stalls with its strobes held and wait_cnt counting.
  assign frozen     = halt_q | err_q;
  assign read_phase = (phase_q == PH_INST_FETCH) ||
                      ((phase_q == PH_OP_FETCH) && is_aluop(opcode));
  assign stall      = !frozen && read_phase && !mem_rdy;
  assign hlt_now    = !frozen && (phase_q == PH_OP_ADDR) && (opcode == OP_HLT);
  assign live       = !RST && !frozen;

  cpu_phase_decode u_decode (
    .phase_i   (phase_q),
    .opcode_i  (opcode),
    .zero_i    (zero),
    .strobes_o (dec_strobes)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      phase_q    <= PH_INST_ADDR;
      wait_cnt_q <= '0;
      halt_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      wait_cnt_q <= wait_cnt_d;
      halt_q     <= halt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    phase_d    = phase_q;
    wait_cnt_d = wait_cnt_q;
    halt_d     = halt_q;
    err_d      = err_q;
    if (frozen) begin
      phase_d = phase_q;
    end else if (stall) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
      if (wait_cnt_q == LAST_WAIT) begin
        err_d  = 1'b1;
        halt_d = 1'b1;
      end
    end else if (hlt_now) begin
      // Phase parks at OP_ADDR for good once HLT is seen.
      halt_d = 1'b1;
    end else begin
      phase_d    = phase_q + 3'd1;
      wait_cnt_d = '0;
    end
  end

  always_comb begin
    sel    = dec_strobes.sel    & live;
    rd     = dec_strobes.rd     & live;
    ld_ir  = dec_strobes.ld_ir  & live & !stall;
    inc_pc = dec_strobes.inc_pc & live;
    ld_pc  = dec_strobes.ld_pc  & live;
    ld_ac  = dec_strobes.ld_ac  & live & !stall;
    wr     = dec_strobes.wr     & live;
    data_e = dec_strobes.data_e & live;
  end

  assign halt  = halt_q;
  assign err   = err_q;
  assign phase = phase_q;

endmodule

// File: tb/tb_cpu_phase_controller.sv
// Bench for cpu_phase_controller: directed scenario tasks plus a randomized run,
// all checked against a behavioural model of the instruction-cycle rules.
module tb_cpu_phase_controller;
  import cpu_pkg::*;

  localparam int WAIT_LIMIT = 15;
  localparam int W          = 13;
  localparam int NRAND      = 1500;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [2:0] opcode = 3'd0;
  logic       zero = 1'b0;
  logic       mem_rdy = 1'b1;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, err;
  logic [2:0] phase;

  int checks   = 0;
  int failures = 0;

  // behavioural model state
  int m_phase = 0;
  int m_wait  = 0;
  bit m_halt  = 1'b0;
  bit m_err   = 1'b0;

  logic [W-1:0] exp_q[$];
  logic [2:0]   r_op  [NRAND];
  logic         r_z   [NRAND];
  logic         r_rdy [NRAND];
  logic         r_rst [NRAND];

  cpu_phase_controller #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .opcode  (opcode),
    .zero    (zero),
    .mem_rdy (mem_rdy),
    .sel     (sel),
    .rd      (rd),
    .ld_ir   (ld_ir),
    .inc_pc  (inc_pc),
    .ld_pc   (ld_pc),
    .ld_ac   (ld_ac),
    .wr      (wr),
    .data_e  (data_e),
    .halt    (halt),
    .err     (err),
    .phase   (phase)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Observed/expected vector layout:
  // {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, err, phase[2:0]}
  function automatic logic [W-1:0] model_out(input logic [2:0] op, input logic z,
                                             input logic rdy, input logic r);
    bit alu, on, stalled;
    bit s_sel, s_rd, s_ldir, s_inc, s_ldpc, s_ldac, s_wr, s_de;
    alu     = op inside {3'd2, 3'd3, 3'd4, 3'd5};
    on      = !r && !m_halt && !m_err;
    stalled = on && !rdy && (m_phase == 1 || (m_phase == 5 && alu));
    s_sel   = on && m_phase <= 3;
    s_rd    = on && ((m_phase >= 1 && m_phase <= 3) || (alu && m_phase >= 5));
    s_ldir  = on && !stalled && (m_phase == 2 || m_phase == 3);
    s_inc   = on && ((m_phase == 4 && op != 3'd0) || (m_phase == 6 && op == 3'd1 && z));
    s_ldpc  = on && op == 3'd7 && m_phase >= 6;
    s_ldac  = on && !stalled && alu && m_phase == 7;
    s_wr    = on && op == 3'd6 && m_phase == 7;
    s_de    = on && op == 3'd6 && m_phase >= 6;
    return {s_sel, s_rd, s_ldir, s_inc, s_ldpc, s_ldac, s_wr, s_de, m_halt, m_err, 3'(m_phase)};
  endfunction

  task automatic model_step(input logic [2:0] op, input logic rdy, input logic r);
    bit alu;
    alu = op inside {3'd2, 3'd3, 3'd4, 3'd5};
    if (r) begin
      m_phase = 0; m_wait = 0; m_halt = 1'b0; m_err = 1'b0;
    end else if (m_halt || m_err) begin
      m_wait = m_wait;
    end else if (!rdy && (m_phase == 1 || (m_phase == 5 && alu))) begin
      if (m_wait == WAIT_LIMIT - 1) begin
        m_err  = 1'b1;
        m_halt = 1'b1;
      end
      m_wait++;
    end else if (m_phase == 4 && op == 3'd0) begin
      m_halt = 1'b1;
    end else begin
      m_phase = (m_phase + 1) % 8;
      m_wait  = 0;
    end
  endtask

  // driver tasks
  task automatic predict(input logic [2:0] op, input logic z, input logic rdy, input logic r,
                         output logic [W-1:0] expv);
    expv = model_out(op, z, rdy, r);
    model_step(op, rdy, r);
  endtask

  task automatic drive(input logic [2:0] op, input logic z, input logic rdy, input logic r,
                       output logic [W-1:0] obs);
    opcode  = op;
    zero    = z;
    mem_rdy = rdy;
    RST     = r;
    @(negedge CLK);
    obs = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, err, phase};
    @(posedge CLK);
    #1;
  endtask

  task automatic step(input logic [2:0] op, input logic z, input logic rdy, input logic r,
                      output logic [W-1:0] obs, output logic [W-1:0] expv);
    predict(op, z, rdy, r, expv);
    drive(op, z, rdy, r, obs);
  endtask

  task automatic reset_dut();
    logic [W-1:0] obs, expv;
    step(OP_LDA, 1'b0, 1'b1, 1'b1, obs, expv);
    step(OP_LDA, 1'b0, 1'b1, 1'b1, obs, expv);
  endtask

  // scenario tasks
  task automatic test_reset();
    logic [W-1:0] obs, expv;
    for (int i = 0; i < 2; i++) begin
      step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1, 1'b1, obs, expv);
      checks++;
      if (obs !== expv) begin
        $display("FAIL reset_cycle%0d got=%b exp=%b", i, obs, expv); failures++;
      end
    end
    step(OP_LDA, 1'b0, 1'b1, 1'b0, obs, expv);
    checks++;
    if (obs !== 13'h1000) begin
      $display("FAIL reset_release got=%b exp=%b", obs, 13'h1000); failures++;
    end
  endtask

  task automatic test_lda_cycle();
    logic [W-1:0] obs, expv;
    logic prev_ldir = 1'b0;
    int ldir_pulses = 0, inc_cnt = 0, ldac_cnt = 0;
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      step(OP_LDA, 1'($urandom_range(0, 1)), 1'b1, 1'b0, obs, expv);
      checks++;
      if (obs !== expv) begin
        $display("FAIL lda_cycle%0d got=%b exp=%b", i, obs, expv); failures++;
      end
      checks++;
      if (obs[2:0] !== 3'(i % 8)) begin
        $display("FAIL lda_phase%0d got=%0d exp=%0d", i, obs[2:0], i % 8); failures++;
      end
      if (obs[10] && !prev_ldir) ldir_pulses++;
      prev_ldir = obs[10];
      if (obs[9]) inc_cnt++;
      if (obs[7]) ldac_cnt++;
    end
    checks++;
    if (ldir_pulses != 2 || inc_cnt != 2 || ldac_cnt != 2) begin
      $display("FAIL lda_strobe_counts got ldir=%0d inc=%0d ldac=%0d exp 2/2/2",
               ldir_pulses, inc_cnt, ldac_cnt); failures++;
    end
  endtask

  task automatic test_halt();
    logic [W-1:0] obs, expv;
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      step(OP_HLT, 1'b0, 1'b1, 1'b0, obs, expv);
      checks++;
      if (obs !== expv) begin
        $display("FAIL halt_pre%0d got=%b exp=%b", i, obs, expv); failures++;
      end
    end
    for (int i = 0; i < 20; i++) begin
      step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'b0, obs, expv);
      checks++;
      if (obs !== 13'h014) begin
        $display("FAIL halt_frozen%0d got=%b exp=%b", i, obs, 13'h014); failures++;
      end
    end
  endtask

  task automatic test_skz();
    logic [W-1:0] obs, expv;
    int inc_cnt;
    for (int zz = 0; zz < 2; zz++) begin
      reset_dut();
      inc_cnt = 0;
      for (int i = 0; i < 8; i++) begin
        step(OP_SKZ, 1'(zz), 1'b1, 1'b0, obs, expv);
        checks++;
        if (obs !== expv) begin
          $display("FAIL skz_z%0d_cyc%0d got=%b exp=%b", zz, i, obs, expv); failures++;
        end
        if (obs[9]) inc_cnt++;
      end
      checks++;
      if (inc_cnt != (zz == 1 ? 2 : 1)) begin
        $display("FAIL skz_inc_count z=%0d got=%0d exp=%0d", zz, inc_cnt, zz == 1 ? 2 : 1);
        failures++;
      end
    end
  endtask

  task automatic test_jmp_sto();
    logic [W-1:0] obs, expv;
    logic [7:0] ldpc_ph, inc_ph, de_ph, wr_ph;
    for (int k = 0; k < 2; k++) begin
      logic [2:0] op;
      op = (k == 0) ? OP_JMP : OP_STO;
      reset_dut();
      ldpc_ph = '0; inc_ph = '0; de_ph = '0; wr_ph = '0;
      for (int i = 0; i < 8; i++) begin
        step(op, 1'($urandom_range(0, 1)), 1'b1, 1'b0, obs, expv);
        checks++;
        if (obs !== expv) begin
          $display("FAIL jmpsto_op%0d_cyc%0d got=%b exp=%b", op, i, obs, expv); failures++;
        end
        if (obs[8]) ldpc_ph[obs[2:0]] = 1'b1;
        if (obs[9]) inc_ph[obs[2:0]]  = 1'b1;
        if (obs[5]) de_ph[obs[2:0]]   = 1'b1;
        if (obs[6]) wr_ph[obs[2:0]]   = 1'b1;
      end
      checks++;
      if (inc_ph !== 8'b0001_0000) begin
        $display("FAIL jmpsto_inc_phases op=%0d got=%b exp=00010000", op, inc_ph); failures++;
      end
      checks++;
      if (k == 0 && ldpc_ph !== 8'b1100_0000) begin
        $display("FAIL jmp_ldpc_phases got=%b exp=11000000", ldpc_ph); failures++;
      end else if (k == 1 && (de_ph !== 8'b1100_0000 || wr_ph !== 8'b1000_0000)) begin
        $display("FAIL sto_phases got de=%b wr=%b exp de=11000000 wr=10000000", de_ph, wr_ph);
        failures++;
      end
    end
  endtask

  task automatic test_fetch_stall();
    logic [W-1:0] obs, expv;
    int rdy_seq[6] = '{1, 0, 0, 0, 1, 1};
    int ph_seq[6]  = '{0, 1, 1, 1, 1, 2};
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      step(OP_ADD, 1'b0, 1'(rdy_seq[i]), 1'b0, obs, expv);
      checks++;
      if (obs !== expv) begin
        $display("FAIL fstall_cyc%0d got=%b exp=%b", i, obs, expv); failures++;
      end
      checks++;
      if (obs[2:0] !== 3'(ph_seq[i]) || obs[3] !== 1'b0 ||
          (i >= 1 && i <= 4 && obs[11] !== 1'b1)) begin
        $display("FAIL fstall_phase%0d got ph=%0d rd=%b err=%b exp ph=%0d", i, obs[2:0],
                 obs[11], obs[3], ph_seq[i]); failures++;
      end
    end
  endtask

  task automatic test_wait_clear();
    logic [W-1:0] obs, expv;
    int run = 0;
    logic rdy;
    reset_dut();
    for (int i = 0; i < 32; i++) begin
      if ((m_phase == 1 || m_phase == 5) && run < 10) begin
        rdy = 1'b0; run++;
      end else begin
        rdy = 1'b1; run = 0;
      end
      step(OP_ADD, 1'b0, rdy, 1'b0, obs, expv);
      checks++;
      if (obs !== expv) begin
        $display("FAIL waitclr_cyc%0d got=%b exp=%b", i, obs, expv); failures++;
      end
    end
    checks++;
    if (obs[4:3] !== 2'b00) begin
      $display("FAIL waitclr_flags got=%b exp=00", obs[4:3]); failures++;
    end
  endtask

  task automatic test_timeout();
    logic [W-1:0] obs, expv;
    reset_dut();
    for (int i = 0; i < 5; i++) step(OP_ADD, 1'b0, 1'b1, 1'b0, obs, expv);
    for (int i = 0; i < WAIT_LIMIT; i++) begin
      step(OP_ADD, 1'b0, 1'b0, 1'b0, obs, expv);
      checks++;
      if (obs !== expv || obs[2:0] !== 3'd5 || obs[3] !== 1'b0 || obs[11] !== 1'b1) begin
        $display("FAIL timeout_stall%0d got=%b exp=%b", i, obs, expv); failures++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(OP_ADD, 1'b0, 1'($urandom_range(0, 1)), 1'b0, obs, expv);
      checks++;
      if (obs !== 13'h01D) begin
        $display("FAIL timeout_flag%0d got=%b exp=%b", i, obs, 13'h01D); failures++;
      end
    end
    step(OP_ADD, 1'b0, 1'b0, 1'b1, obs, expv);
    checks++;
    if (obs !== expv) begin
      $display("FAIL timeout_rst got=%b exp=%b", obs, expv); failures++;
    end
    step(OP_ADD, 1'b0, 1'b0, 1'b0, obs, expv);
    checks++;
    if (obs !== 13'h1000) begin
      $display("FAIL timeout_recover got=%b exp=%b", obs, 13'h1000); failures++;
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] obs, expv;
    int n;
    reset_dut();
    n = $urandom_range(3, 12);
    for (int i = 0; i < n; i++) step(OP_STO, 1'b0, 1'b1, 1'b0, obs, expv);
    step(OP_STO, 1'b0, 1'b0, 1'b1, obs, expv);
    checks++;
    if (obs[12:5] !== 8'h00) begin
      $display("FAIL midrst_strobes got=%b exp=00000000", obs[12:5]); failures++;
    end
    step(OP_STO, 1'b0, 1'b1, 1'b0, obs, expv);
    checks++;
    if (obs !== 13'h1000) begin
      $display("FAIL midrst_phase0 got=%b exp=%b", obs, 13'h1000); failures++;
    end
  endtask

  task automatic test_random();
    logic [W-1:0] obs, expv;
    int burst = 0;
    reset_dut();
    for (int i = 0; i < NRAND; i++) begin
      if (burst == 0 && $urandom_range(0, 99) == 0) burst = 16;
      r_rst[i] = ($urandom_range(0, 49) == 0);
      r_op[i]  = ($urandom_range(0, 15) == 0) ? OP_HLT : 3'($urandom_range(1, 7));
      r_z[i]   = 1'($urandom_range(0, 1));
      r_rdy[i] = (burst > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (burst > 0) burst--;
      predict(r_op[i], r_z[i], r_rdy[i], r_rst[i], expv);
      exp_q.push_back(expv);
    end
    for (int i = 0; i < NRAND; i++) begin
      drive(r_op[i], r_z[i], r_rdy[i], r_rst[i], obs);
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        $display("FAIL random_cyc%0d got=%b exp=%b", i, obs, expv); failures++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_lda_cycle();
    test_halt();
    test_skz();
    test_jmp_sto();
    test_fetch_stall();
    test_wait_clear();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
